// File: rtl/npc_rf_pkg.sv
// Shared constants and types for the integer register-file write-back path.
// Holds default widths and the write-back requester identifiers.
// No logic; imported by the interface users and the controller modules.
package npc_rf_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;

  // Requester identity, also used as the round-robin last-grant pointer.
  typedef enum logic {
    REQ_EXU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

endpackage : npc_rf_pkg

// File: rtl/rf_wb_ctrl_if.sv
// Issue-stage hazard handshake, two write-back requesters and the RF write port.
// Pure wiring bundle: no latency of its own.
// slave = controller side (drives readies and the RF port), master = surroundings.
interface rf_wb_ctrl_if #(
  parameter int ADDR_WIDTH = npc_rf_pkg::DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = npc_rf_pkg::DEF_DATA_WIDTH
) ();

  logic                  iss_valid;
  logic [ADDR_WIDTH-1:0] iss_rs1;
  logic [ADDR_WIDTH-1:0] iss_rs2;
  logic [ADDR_WIDTH-1:0] iss_rd;
  logic                  iss_wen;
  logic                  iss_ready;

  logic                  exu_valid;
  logic [ADDR_WIDTH-1:0] exu_rd;
  logic [DATA_WIDTH-1:0] exu_wdata;
  logic                  exu_ready;

  logic                  lsu_valid;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_wdata;
  logic                  lsu_ready;

  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_rd;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  sb_err;

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wen,
    output iss_ready,
    input  exu_valid, exu_rd, exu_wdata,
    output exu_ready,
    input  lsu_valid, lsu_rd, lsu_wdata,
    output lsu_ready,
    output rf_wen, rf_rd, rf_wdata, sb_err
  );

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wen,
    input  iss_ready,
    output exu_valid, exu_rd, exu_wdata,
    input  exu_ready,
    output lsu_valid, lsu_rd, lsu_wdata,
    input  lsu_ready,
    input  rf_wen, rf_rd, rf_wdata, sb_err
  );

endinterface : rf_wb_ctrl_if

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard with one set port, one clear port and three lookups.
// Lookups are combinational on the registered busy vector; updates land at the edge.
// No backpressure; a set and clear of the same index in one cycle leaves it busy.
module rf_scoreboard import npc_rf_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        set_en_i,
  input  logic [ADDR_WIDTH-1:0]       set_idx_i,
  input  logic                        clr_en_i,
  input  logic [ADDR_WIDTH-1:0]       clr_idx_i,
  input  logic [ADDR_WIDTH-1:0]       rd_idx_a_i,
  input  logic [ADDR_WIDTH-1:0]       rd_idx_b_i,
  input  logic [ADDR_WIDTH-1:0]       rd_idx_c_i,
  output logic                        busy_a_o,
  output logic                        busy_b_o,
  output logic                        busy_c_o,
  output logic [(1<<ADDR_WIDTH)-1:0]  busy_o
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Next busy vector: clear first so a coincident set wins; x0 is never busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    if (set_en_i) busy_d[set_idx_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy vector register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_a_o = busy_q[rd_idx_a_i];
  assign busy_b_o = busy_q[rd_idx_b_i];
  assign busy_c_o = busy_q[rd_idx_c_i];
  assign busy_o   = busy_q;

endmodule : rf_scoreboard

// File: rtl/rf_wb_ctrl.sv
// Write-back controller: round-robin EXU/LSU onto the single RF write port + hazard scoreboard.
// Grant in cycle N drives the registered RF write in N+1; dependent issue unblocks in N+2.
// Ready only accompanies valid, at most one grant per cycle; issue stalls while a source/dest is busy.
module rf_wb_ctrl import npc_rf_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  rf_wb_ctrl_if.slave bus
);

  localparam int NREG = 1 << ADDR_WIDTH;

  req_e                  last_q, last_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                  sb_err_q, sb_err_d;

  logic                  exu_gnt, lsu_gnt, gnt;
  logic [ADDR_WIDTH-1:0] gnt_rd;
  logic [DATA_WIDTH-1:0] gnt_wdata;
  logic                  gnt_rd_nz;

  logic                  busy_rs1, busy_rs2, busy_rd;
  logic [NREG-1:0]       busy_vec;
  logic                  iss_ready;
  logic                  dispatch;

  rf_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en_i   (dispatch),
    .set_idx_i  (bus.iss_rd),
    .clr_en_i   (rf_wen_q),
    .clr_idx_i  (rf_rd_q),
    .rd_idx_a_i (bus.iss_rs1),
    .rd_idx_b_i (bus.iss_rs2),
    .rd_idx_c_i (bus.iss_rd),
    .busy_a_o   (busy_rs1),
    .busy_b_o   (busy_rs2),
    .busy_c_o   (busy_rd),
    .busy_o     (busy_vec)
  );

  // Hazard check and dispatch; no bypass from the write port, so a consumer waits for the commit.
  always_comb begin
    iss_ready = ~(busy_rs1 | busy_rs2 | (bus.iss_wen & busy_rd));
    dispatch  = bus.iss_valid & iss_ready & bus.iss_wen & (bus.iss_rd != '0);
  end

  // Round-robin grant: a lone requester wins, on a tie the one not granted last wins.
  always_comb begin
    exu_gnt   = bus.exu_valid & (~bus.lsu_valid | (last_q == REQ_LSU));
    lsu_gnt   = bus.lsu_valid & (~bus.exu_valid | (last_q == REQ_EXU));
    gnt       = exu_gnt | lsu_gnt;
    gnt_rd    = exu_gnt ? bus.exu_rd    : bus.lsu_rd;
    gnt_wdata = exu_gnt ? bus.exu_wdata : bus.lsu_wdata;
    gnt_rd_nz = gnt_rd != '0;
    last_d    = last_q;
    if (exu_gnt)      last_d = REQ_EXU;
    else if (lsu_gnt) last_d = REQ_LSU;
  end

  // Write-port next state; index/data hold when idle, error flags a write to a non-busy register.
  always_comb begin
    rf_wen_d   = gnt & gnt_rd_nz;
    rf_rd_d    = gnt ? gnt_rd    : rf_rd_q;
    rf_wdata_d = gnt ? gnt_wdata : rf_wdata_q;
    sb_err_d   = sb_err_q | (gnt & gnt_rd_nz & ~busy_vec[gnt_rd]);
  end

  // Pointer and write-port registers; async reset drops any in-flight write immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= REQ_LSU;
      rf_wen_q   <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      last_q     <= last_d;
      rf_wen_q   <= rf_wen_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      sb_err_q   <= sb_err_d;
    end
  end

  assign bus.iss_ready = iss_ready;
  assign bus.exu_ready = exu_gnt;
  assign bus.lsu_ready = lsu_gnt;
  assign bus.rf_wen    = rf_wen_q;
  assign bus.rf_rd     = rf_rd_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.sb_err    = sb_err_q;

endmodule : rf_wb_ctrl

// File: tb/tb_rf_wb_ctrl.sv
// Bench for rf_wb_ctrl: directed vector table, reset/fairness sequences, random vs reference model.
// Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
// Requesters in the random phase hold their payload until granted.
module tb_rf_wb_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  rf_wb_ctrl_if bus ();

  rf_wb_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [4:0]  rs1, rs2, rd;
    logic        wen;
    logic        ev;
    logic [4:0]  erd;
    logic [31:0] ed;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        x_iss, x_er, x_lr, x_wen;
    logic [4:0]  x_rd;
    logic [31:0] x_wd;
    logic        x_err;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(
    input logic iv, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
    input logic wen, input logic ev, input logic [4:0] erd, input logic [31:0] ed,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
    input logic x_iss, input logic x_er, input logic x_lr, input logic x_wen,
    input logic [4:0] x_rd, input logic [31:0] x_wd, input logic x_err);
    vec_t v;
    v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.wen = wen;
    v.ev = ev; v.erd = erd; v.ed = ed; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.x_iss = x_iss; v.x_er = x_er; v.x_lr = x_lr; v.x_wen = x_wen;
    v.x_rd = x_rd; v.x_wd = x_wd; v.x_err = x_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic iv, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
    input logic wen, input logic ev, input logic [4:0] erd, input logic [31:0] ed,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    bus.iss_valid = iv;  bus.iss_rs1 = rs1; bus.iss_rs2 = rs2; bus.iss_rd = rd; bus.iss_wen = wen;
    bus.exu_valid = ev;  bus.exu_rd = erd;  bus.exu_wdata = ed;
    bus.lsu_valid = lv;  bus.lsu_rd = lrd;  bus.lsu_wdata = ld;
  endtask

  // Reference model state: busy flags per register, last granted requester, RF port image.
  bit          mb[32];
  int          m_last;     // 0 = EXU, 1 = LSU
  logic        m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic        m_err;

  // Random requester state.
  logic        e_pend, l_pend;
  logic [4:0]  e_rd, l_rd;
  logic [31:0] e_wd, l_wd;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //        iv rs1 rs2 rd wen  ev erd ed            lv lrd ld       iss er lr wen rd wd            err
    tbl[0]  = mk(1, 3, 4, 1, 1,  0, 0, 0,            0, 0, 0,        1, 0, 0, 0, 0, 0,            0);
    tbl[1]  = mk(1, 0, 0, 2, 1,  0, 0, 0,            0, 0, 0,        1, 0, 0, 0, 0, 0,            0);
    tbl[2]  = mk(0, 1, 2, 0, 0,  1, 1, 32'h11,       1, 2, 32'h22,   0, 1, 0, 0, 0, 0,            0);
    tbl[3]  = mk(0, 1, 2, 0, 0,  0, 0, 0,            1, 2, 32'h22,   0, 0, 1, 1, 1, 32'h11,       0);
    tbl[4]  = mk(0, 1, 0, 0, 0,  0, 0, 0,            0, 0, 0,        1, 0, 0, 1, 2, 32'h22,       0);
    tbl[5]  = mk(1, 3, 4, 5, 1,  0, 0, 0,            0, 0, 0,        1, 0, 0, 0, 2, 32'h22,       0);
    tbl[6]  = mk(1, 5, 0, 6, 1,  0, 0, 0,            0, 0, 0,        0, 0, 0, 0, 2, 32'h22,       0);
    tbl[7]  = mk(1, 5, 0, 6, 1,  1, 5, 32'hDEADBEEF, 0, 0, 0,        0, 1, 0, 0, 2, 32'h22,       0);
    tbl[8]  = mk(1, 5, 0, 6, 1,  0, 0, 0,            0, 0, 0,        0, 0, 0, 1, 5, 32'hDEADBEEF, 0);
    tbl[9]  = mk(0, 5, 0, 6, 1,  0, 0, 0,            0, 0, 0,        1, 0, 0, 0, 5, 32'hDEADBEEF, 0);
    tbl[10] = mk(1, 0, 0, 0, 1,  0, 0, 0,            1, 0, 32'h55,   1, 0, 1, 0, 5, 32'hDEADBEEF, 0);
    tbl[11] = mk(0, 0, 0, 0, 1,  0, 0, 0,            0, 0, 0,        1, 0, 0, 0, 0, 32'h55,       0);
    tbl[12] = mk(0, 0, 0, 0, 0,  1, 7, 32'h77,       0, 0, 0,        1, 1, 0, 0, 0, 32'h55,       0);
    tbl[13] = mk(0, 7, 0, 0, 0,  0, 0, 0,            0, 0, 0,        1, 0, 0, 1, 7, 32'h77,       1);
    tbl[14] = mk(0, 7, 0, 7, 1,  0, 0, 0,            0, 0, 0,        1, 0, 0, 0, 7, 32'h77,       1);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table: contention from reset, RAW stall, x0 write-back, protocol error.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(tbl[i].iv, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].wen,
            tbl[i].ev, tbl[i].erd, tbl[i].ed, tbl[i].lv, tbl[i].lrd, tbl[i].ld);
      #1;
      chk($sformatf("vec%0d iss_ready", i), 32'(bus.iss_ready), 32'(tbl[i].x_iss));
      chk($sformatf("vec%0d exu_ready", i), 32'(bus.exu_ready), 32'(tbl[i].x_er));
      chk($sformatf("vec%0d lsu_ready", i), 32'(bus.lsu_ready), 32'(tbl[i].x_lr));
      chk($sformatf("vec%0d rf_wen", i),    32'(bus.rf_wen),    32'(tbl[i].x_wen));
      chk($sformatf("vec%0d rf_rd", i),     32'(bus.rf_rd),     32'(tbl[i].x_rd));
      chk($sformatf("vec%0d rf_wdata", i),  bus.rf_wdata,       tbl[i].x_wd);
      chk($sformatf("vec%0d sb_err", i),    32'(bus.sb_err),    32'(tbl[i].x_err));
    end

    // Mid-stream reset: a write is in flight and x5 is busy; reset must clear both with no clock edge.
    @(negedge clk);
    drive(1, 0, 0, 5, 1, 1, 7, 32'h77, 0, 0, 0);
    #1 chk("rst_pre exu_ready", 32'(bus.exu_ready), 32'd1);
    @(negedge clk);
    drive(0, 3, 4, 5, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_pre rf_wen", 32'(bus.rf_wen), 32'd1);
    chk("rst_pre iss_ready", 32'(bus.iss_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst rf_wen", 32'(bus.rf_wen), 32'd0);
    chk("rst sb_err", 32'(bus.sb_err), 32'd0);
    chk("rst iss_ready", 32'(bus.iss_ready), 32'd1);
    chk("rst rf_rd", 32'(bus.rf_rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness under continuous contention from reset: EXU, LSU, EXU, ...
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 1, 0, 32'(i), 1, 0, 32'(i + 100));
      #1;
      chk($sformatf("rr%0d exu_ready", i), 32'(bus.exu_ready), 32'((i % 2) == 0));
      chk($sformatf("rr%0d lsu_ready", i), 32'(bus.lsu_ready), 32'((i % 2) == 1));
      chk($sformatf("rr%0d one_ready", i), 32'(bus.exu_ready & bus.lsu_ready), 32'd0);
    end

    // Random phase against the reference model, from a fresh reset.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 32; r++) mb[r] = 1'b0;
    m_last = 1; m_wen = 1'b0; m_rd = '0; m_wd = '0; m_err = 1'b0;
    e_pend = 1'b0; l_pend = 1'b0; e_rd = '0; l_rd = '0; e_wd = '0; l_wd = '0;

    for (int c = 0; c < 400; c++) begin
      logic        iv, wen, x_iss, x_eg, x_lg, g, nerr;
      logic [4:0]  rs1, rs2, rd, grd;
      logic [31:0] gwd;
      @(negedge clk);
      if (!e_pend && $urandom_range(0, 2) != 0) begin
        e_pend = 1'b1; e_rd = 5'($urandom_range(0, 7)); e_wd = $urandom;
      end
      if (!l_pend && $urandom_range(0, 2) != 0) begin
        l_pend = 1'b1; l_rd = 5'($urandom_range(0, 7)); l_wd = $urandom;
      end
      iv  = 1'($urandom_range(0, 1));
      wen = 1'($urandom_range(0, 1));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      drive(iv, rs1, rs2, rd, wen, e_pend, e_rd, e_wd, l_pend, l_rd, l_wd);
      #1;
      x_iss = !(mb[rs1] || mb[rs2] || (wen && mb[rd]));
      x_eg  = e_pend && (!l_pend || m_last == 1);
      x_lg  = l_pend && (!e_pend || m_last == 0);
      chk($sformatf("rnd%0d iss_ready", c), 32'(bus.iss_ready), 32'(x_iss));
      chk($sformatf("rnd%0d exu_ready", c), 32'(bus.exu_ready), 32'(x_eg));
      chk($sformatf("rnd%0d lsu_ready", c), 32'(bus.lsu_ready), 32'(x_lg));
      chk($sformatf("rnd%0d rf_wen", c),    32'(bus.rf_wen),    32'(m_wen));
      chk($sformatf("rnd%0d rf_rd", c),     32'(bus.rf_rd),     32'(m_rd));
      chk($sformatf("rnd%0d rf_wdata", c),  bus.rf_wdata,       m_wd);
      chk($sformatf("rnd%0d sb_err", c),    32'(bus.sb_err),    32'(m_err));

      // Advance the model across the coming rising edge.
      g    = x_eg || x_lg;
      grd  = x_eg ? e_rd : l_rd;
      gwd  = x_eg ? e_wd : l_wd;
      nerr = m_err || (g && grd != 0 && !mb[grd]);
      if (m_wen) mb[m_rd] = 1'b0;
      if (iv && x_iss && wen && rd != 0) mb[rd] = 1'b1;
      m_err = nerr;
      if (g) begin
        m_wen  = (grd != 0);
        m_rd   = grd;
        m_wd   = gwd;
        m_last = x_eg ? 0 : 1;
      end else begin
        m_wen = 1'b0;
      end
      if (x_eg) e_pend = 1'b0;
      if (x_lg) l_pend = 1'b0;
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rf_wb_ctrl
